spi_bridge_master: RTL
======================

SPI_BRIDGE_MASTER -- requirements
Module: spi_bridge_master

Interface
REQ-001 Parameter CLK_DIV, default 2, meaning SCLK half-period in HCLK cycles (legal 1..255).
REQ-002 HCLK  input  1  system clock; all logic on rising edge.
REQ-003 HRESETn  input  1  asynchronous, active-low reset.
REQ-004 WriteFIFO_dout  input  41  queued command word {rw, cmd[7:0], data[31:0]}; rw=1 write, rw=0 read.
REQ-005 WriteFIFO_empty  input  1  command FIFO empty.
REQ-006 WriteFIFO_rd_en  output  1  one-cycle pop; FIFO data is valid on the cycle after the pop.
REQ-007 ReadFIFO_din  output  32  read data to the AHB side.
REQ-008 ReadFIFO_wr_en  output  1  one-cycle push of ReadFIFO_din.
REQ-009 ReadFIFO_full  input  1  read FIFO full.
REQ-010 SCLK  output  1  SPI clock, mode 0 (idles low).
REQ-011 MOSI  output  1  serial data out, MSB first.
REQ-012 MISO  input  1  serial data in.
REQ-013 SS_n  output  1  active-low slave select.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, FETCH, LOAD, SHIFT, PUSH.
REQ-016 IDLE: if WriteFIFO_empty=0, assert WriteFIFO_rd_en for one cycle and go to FETCH; otherwise stay in IDLE.
REQ-017 FETCH: wait exactly one cycle, then go to LOAD.
REQ-018 LOAD: latch WriteFIFO_dout into a 41-bit shift register, drive SS_n=0 and MOSI=bit40, clear the bit counter and divider, then go to SHIFT.
REQ-019 Every frame is 41 SCLK periods; each period is CLK_DIV cycles low then CLK_DIV cycles high; frame duration is 82*CLK_DIV HCLK cycles.
REQ-020 MISO is sampled on each SCLK rising edge; MOSI advances to the next bit on each SCLK falling edge.
REQ-021 Write frame (rw=1): all 41 bits are driven on MOSI.
REQ-022 Read frame (rw=0): bits 40..32 are driven; MOSI=0 for the remaining 32 bits; the MISO samples from SCLK periods 10..41 form the read word, MSB first.
REQ-023 After the 41st falling edge: SCLK=0, SS_n=1, bit counter=41 (6-bit counter).
REQ-024 Write frame end: go to IDLE.
REQ-025 Read frame end: go to PUSH.
REQ-026 PUSH: if ReadFIFO_full=0, drive ReadFIFO_din with the read word, pulse ReadFIFO_wr_en for one cycle, and go to IDLE; if ReadFIFO_full=1, hold in PUSH with data retained and no push.
REQ-027 SS_n shall be high for at least 3 HCLK cycles between frames (PUSH/IDLE, IDLE, FETCH), even with back-to-back commands.
REQ-028 WriteFIFO_empty is ignored outside IDLE; at most one pop per frame; no pop while in PUSH.
REQ-029 Read data is never dropped or duplicated; exactly one push per read frame.
REQ-030 WriteFIFO_rd_en and ReadFIFO_wr_en are registered outputs and are never high in the same cycle.

Reset
REQ-031 On HRESETn=0, immediately: state=IDLE, SCLK=0, SS_n=1, MOSI=0, busy=0, WriteFIFO_rd_en=0, ReadFIFO_wr_en=0, ReadFIFO_din=0, counters and shift registers=0.
REQ-032 Reset mid-frame aborts the frame with no FIFO push; the popped command is lost, not re-fetched.
REQ-033 After reset release, the first pop occurs no earlier than the first rising HCLK edge with WriteFIFO_empty=0.

Structure
REQ-034 Shared package spi_bridge_pkg holds:
- the state enum;
- FRAME_BITS=41, HDR_BITS=9, DATA_BITS=32;
- field positions RW_BIT=40, CMD_MSB=39, CMD_LSB=32.
The AHB slave shall use the same package.
REQ-035 One sub-module, spi_clk_gen, is natural: it generates the divider, SCLK, and one-cycle rise/fall strobes from CLK_DIV.
REQ-036 Total RTL in the 120-400 line range.

Verification
REQ-037 Write frame, CLK_DIV=2, WriteFIFO word {1,8'hA5,32'hDEADBEEF} -> MOSI carries 1,A5,DEADBEEF MSB first; SS_n low for 164 cycles; no ReadFIFO_wr_en.
REQ-038 Read frame, word {0,8'h3C,32'h0}, slave model returns 32'h12345678 -> MOSI carries 0,3C then 32 zeros; one ReadFIFO_wr_en with ReadFIFO_din=32'h12345678.
REQ-039 Read frame with ReadFIFO_full=1 held for 20 cycles after frame end -> FSM stays in PUSH, busy=1; push occurs on the first cycle after full clears, data intact.
REQ-040 Three back-to-back writes, FIFO never empty -> exactly 3 pops, 3 frames, SS_n high ≥3 cycles between frames.
REQ-041 HRESETn asserted at SCLK period 20 of a read frame -> SS_n=1 and SCLK=0 asynchronously, no push; the next queued word starts a clean frame after release.
REQ-042 CLK_DIV=1, write 41'h1_FF_00000001 -> SCLK toggles every HCLK cycle; frame lasts 82 cycles; last MOSI bit=1.

Source files
------------

// File: rtl/spi_bridge_pkg.sv
// ---------------------------------------------------------------------------
// spi_bridge_pkg
// Shared definitions for the AHB-to-SPI bridge (master FSM and AHB slave).
//   state_e      : master FSM states
//   FRAME_BITS   : SPI frame length {rw, cmd[7:0], data[31:0]}
//   HDR_BITS     : rw + command byte, always driven on MOSI
//   DATA_BITS    : data field width
//   RW_BIT, CMD_MSB, CMD_LSB : field positions inside a command word
// ---------------------------------------------------------------------------
package spi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    PUSH  = 3'd4
  } state_e;

  localparam int FRAME_BITS = 41;
  localparam int HDR_BITS   = 9;
  localparam int DATA_BITS  = 32;

  localparam int RW_BIT  = 40;
  localparam int CMD_MSB = 39;
  localparam int CMD_LSB = 32;

endpackage : spi_bridge_pkg

// File: rtl/spi_clk_gen.sv
// ---------------------------------------------------------------------------
// spi_clk_gen
// SPI mode-0 clock generator. While en_i is high, SCLK spends CLK_DIV HCLK
// cycles low then CLK_DIV cycles high, starting low. While en_i is low the
// divider and SCLK are held at zero.
// Ports:
//   HCLK, HRESETn : system clock, async active-low reset
//   en_i          : run the divider (frame in progress)
//   sclk_o        : registered SPI clock
//   rise_o        : high in the cycle whose closing HCLK edge raises SCLK
//   fall_o        : high in the cycle whose closing HCLK edge lowers SCLK
// ---------------------------------------------------------------------------
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_q, div_d;
  logic       sclk_q, sclk_d;
  logic       wrap_s;

  // Divider count and SCLK toggle at the end of each half-period.
  always_comb begin
    wrap_s = (div_q == DIV_LAST);
    div_d  = div_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      div_d  = 8'd0;
      sclk_d = 1'b0;
    end else if (wrap_s) begin
      div_d  = 8'd0;
      sclk_d = ~sclk_q;
    end else begin
      div_d  = div_q + 8'd1;
    end
  end

  // Divider and SCLK registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_q  <= 8'd0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  // Strobes announce the toggle that the coming HCLK edge performs, so the
  // master updates MOSI/samples MISO on the same edge that moves SCLK.
  assign rise_o = en_i & wrap_s & ~sclk_q;
  assign fall_o = en_i & wrap_s &  sclk_q;
  assign sclk_o = sclk_q;

endmodule : spi_clk_gen

// File: rtl/spi_bridge_master.sv
// ---------------------------------------------------------------------------
// spi_bridge_master
// Pops 41-bit command words from the write FIFO, sends each one as an SPI
// mode-0 frame (MSB first) and, for read commands, pushes the 32-bit word
// captured from MISO into the read FIFO.
// Ports:
//   HCLK, HRESETn        : system clock, async active-low reset
//   WriteFIFO_dout/empty : command word {rw, cmd, data} and empty flag
//   WriteFIFO_rd_en      : one-cycle pop (data valid the cycle after)
//   ReadFIFO_din/wr_en   : read word and one-cycle push
//   ReadFIFO_full        : read FIFO full, stalls the push
//   SCLK, MOSI, MISO     : SPI bus, SS_n active-low select
//   busy                 : high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module spi_bridge_master
  import spi_bridge_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [40:0] WriteFIFO_dout,
  input  logic        WriteFIFO_empty,
  output logic        WriteFIFO_rd_en,
  output logic [31:0] ReadFIFO_din,
  output logic        ReadFIFO_wr_en,
  input  logic        ReadFIFO_full,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        SS_n,
  output logic        busy
);

  localparam logic [5:0] LAST_BIT  = 6'(FRAME_BITS - 1);
  localparam logic [5:0] HDR_LAST  = 6'(HDR_BITS - 1);
  localparam logic [5:0] HDR_COUNT = 6'(HDR_BITS);

  state_e      state_q, state_d;
  logic [40:0] shreg_q, shreg_d;
  logic [31:0] rx_q, rx_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        rw_q, rw_d;
  logic        mosi_q, mosi_d;
  logic        ss_n_q, ss_n_d;
  logic        busy_q, busy_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] din_q, din_d;

  logic        sclk_s, rise_s, fall_s;
  logic        shift_en_s;

  assign shift_en_s = (state_q == SHIFT);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .en_i    (shift_en_s),
    .sclk_o  (sclk_s),
    .rise_o  (rise_s),
    .fall_o  (fall_s)
  );

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    rw_d      = rw_q;
    mosi_d    = mosi_q;
    ss_n_d    = ss_n_q;
    din_d     = din_q;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!WriteFIFO_empty) begin
          rd_en_d = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end

      FETCH: begin
        state_d = LOAD;
      end

      LOAD: begin
        shreg_d   = WriteFIFO_dout;
        rw_d      = WriteFIFO_dout[RW_BIT];
        mosi_d    = WriteFIFO_dout[RW_BIT];
        ss_n_d    = 1'b0;
        bit_cnt_d = 6'd0;
        rx_d      = 32'd0;
        state_d   = SHIFT;
      end

      SHIFT: begin
        // bit_cnt_q counts completed SCLK periods; periods 10..41 carry data.
        if (rise_s && (bit_cnt_q >= HDR_COUNT)) begin
          rx_d = {rx_q[30:0], MISO};
        end else begin
          rx_d = rx_q;
        end
        if (fall_s) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
          // Rotate so bit 39 of the current word is next on MOSI.
          shreg_d   = {shreg_q[39:0], shreg_q[40]};
          if (bit_cnt_q == LAST_BIT) begin
            mosi_d  = 1'b0;
            ss_n_d  = 1'b1;
            state_d = rw_q ? IDLE : PUSH;
          end else if (rw_q || (bit_cnt_q < HDR_LAST)) begin
            mosi_d  = shreg_q[39];
          end else begin
            mosi_d  = 1'b0;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end

      PUSH: begin
        if (!ReadFIFO_full) begin
          din_d   = rx_q;
          wr_en_d = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = PUSH;
        end
      end

      default: begin
        state_d = IDLE;
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      shreg_q   <= 41'd0;
      rx_q      <= 32'd0;
      bit_cnt_q <= 6'd0;
      rw_q      <= 1'b0;
      mosi_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      din_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
      rw_q      <= rw_d;
      mosi_q    <= mosi_d;
      ss_n_q    <= ss_n_d;
      busy_q    <= busy_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      din_q     <= din_d;
    end
  end

  assign WriteFIFO_rd_en = rd_en_q;
  assign ReadFIFO_wr_en  = wr_en_q;
  assign ReadFIFO_din    = din_q;
  assign SCLK            = sclk_s;
  assign MOSI            = mosi_q;
  assign SS_n            = ss_n_q;
  assign busy            = busy_q;

endmodule : spi_bridge_master
